// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulate-and-sum accelerator.
// Used by acc_adder and acc_sum_engine.
package acc_pkg;

  localparam int ACC_ADDR_W = 6;
  localparam int ACC_DATA_W = 32;

  localparam logic [ACC_DATA_W-1:0] ACC_SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [ACC_DATA_W-1:0] ACC_SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

endpackage

// File: rtl/acc_adder.sv
// Combinational accumulate adder.
// ACC_SATURATE_EN selects a signed saturating add; otherwise the add wraps.
module acc_adder
  import acc_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef ACC_SATURATE_EN
  logic w_ovf;

  // Overflow only when both operands share a sign that the raw result loses
  assign w_ovf = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_raw[DATA_W-1] != i_a[DATA_W-1]);

  always_comb begin
    o_sum = w_raw;
    if (w_ovf) begin
      o_sum = i_a[DATA_W-1] ? DATA_W'(ACC_SAT_MIN) : DATA_W'(ACC_SAT_MAX);
    end
  end
`else
  assign o_sum = w_raw;
`endif

endmodule

// File: rtl/acc_sum_engine.sv
// Memory-side accelerator: sums a block of data-memory words and writes the
// sum to the word after the block. Optional ACC_SATURATE_EN saturates the add.
module acc_sum_engine
  import acc_pkg::*;
#(
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int DATA_W = ACC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bypass,
  input  logic [ADDR_W-1:0] startaddr,
  input  logic [ADDR_W-1:0] datasize,
  input  logic [DATA_W-1:0] memrdata,
  output logic [ADDR_W-1:0] memaddr,
  output logic              memwe,
  output logic [DATA_W-1:0] memwdata,
  output logic              busy,
  output logic              accdone,
  output logic [DATA_W-1:0] result
);

  acc_state_e        r_state;
  acc_state_e        w_nextState;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_addSum;

  acc_adder #(
    .DATA_W(DATA_W)
  ) u_adder (
    .i_a  (r_sum),
    .i_b  (memrdata),
    .o_sum(w_addSum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (start && !bypass) begin
            r_ptr <= startaddr;
            r_cnt <= datasize;
            r_sum <= '0;
          end
        end
        READ: begin
          r_sum <= w_addSum;
          r_ptr <= r_ptr + ADDR_W'(1);
          r_cnt <= r_cnt - ADDR_W'(1);
        end
        WRITE: begin
          r_result <= r_sum;
        end
        default: ;
      endcase
    end
  end

  // Memory port is only driven in READ/WRITE so the top-level mux sees zeros otherwise
  always_comb begin
    w_nextState = r_state;
    memaddr     = '0;
    memwe       = 1'b0;
    memwdata    = '0;
    accdone     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (bypass) begin
            w_nextState = DONE;
          end else if (datasize == '0) begin
            w_nextState = WRITE;
          end else begin
            w_nextState = READ;
          end
        end
      end
      READ: begin
        memaddr = r_ptr;
        if (r_cnt == ADDR_W'(1)) begin
          w_nextState = WRITE;
        end
      end
      WRITE: begin
        memaddr     = r_ptr;
        memwe       = 1'b1;
        memwdata    = r_sum;
        w_nextState = DONE;
      end
      DONE: begin
        accdone     = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign busy   = (r_state != IDLE);
  assign result = r_result;

endmodule

// File: doc/acc_sum_engine.md
# acc_sum_engine

Memory-side accelerator that consumes the accelerator request issued by the pipelined MIPS core (start, bypass flag, start word address, word count) and returns a one-cycle done pulse. On each request it reads `datasize` consecutive 32-bit words from data memory, starting at word `startaddr`, and sums them. It writes the sum to the word immediately after the block. It sits between the core's accelerator port and the word-addressed data memory; the top level muxes the memory address/write port to this block whenever `busy` is high.

## Interface
- `ADDR_W`, 6, data-memory word-address width (64 words)
- `DATA_W`, 32, data word width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request strobe, sampled only in IDLE
- `bypass`  in  1  sampled with `start`; 1 = skip computation
- `startaddr`  in  ADDR_W  first word address of block
- `datasize`  in  ADDR_W  number of words to sum (0..63)
- `memrdata`  in  DATA_W  data-memory read data (combinational read of `memaddr`)
- `memaddr`  out  ADDR_W  data-memory word address
- `memwe`  out  1  data-memory write enable (memory writes on the rising edge)
- `memwdata`  out  DATA_W  data-memory write data
- `busy`  out  1  high in every state except IDLE
- `accdone`  out  1  one-cycle completion pulse to the core
- `result`  out  DATA_W  last computed sum, held until next non-bypass completion

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `start`=1, `bypass`=0, `datasize`≠0 → READ; load `ptr`=`startaddr`, `cnt`=`datasize`, `sum`=0.
  - `start`=1, `bypass`=0, `datasize`=0 → WRITE; load `ptr`=`startaddr`, `sum`=0.
  - `start`=1, `bypass`=1 → DONE; no memory access.
- **READ**
  - Outputs: `memaddr`=`ptr`, `memwe`=0.
  - Updates: `sum`←`sum`+`memrdata`; `ptr`←`ptr`+1 (mod 2^ADDR_W, wraps 63→0); `cnt`←`cnt`−1.
  - Exit to WRITE when `cnt`==1.
- **WRITE**: `memaddr`=`ptr` (=`startaddr`+`datasize` mod 64), `memwe`=1, `memwdata`=`sum`; `result`←`sum`; → DONE.
- **DONE**: `accdone`=1 → IDLE.
- Addition is DATA_W-bit two's-complement. Default is wrap-around (carry discarded). See Configuration.
- `start` in any state other than IDLE is ignored. No queuing.
- Inputs `startaddr`/`datasize`/`bypass` are sampled only at the accepting edge and may change afterwards.
- A write target inside the summed range is impossible: the target is always the word after the last summed word. Wrap past word 63 is permitted.
- `memaddr`=0, `memwe`=0, `memwdata`=0 in IDLE and DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `accdone`=0, `memwe`=0, `memaddr`=0, `memwdata`=0, `result`=0, internal `ptr`/`cnt`/`sum`=0.
- Reset asserted mid-operation: at that edge the block returns to IDLE with all the above values. `memwe` is low from the next cycle, and a pending write is not performed. `accdone` is not issued.
- Start accepted at edge E0:
  - READ occupies cycles 1..N (N=`datasize`).
  - WRITE occupies cycle N+1; the memory write commits at the end of that cycle.
  - `accdone` is high during cycle N+2.
  - Back in IDLE at cycle N+3, where a new `start` can be accepted.
- `datasize`=0: WRITE in cycle 1, `accdone` in cycle 2.
- Bypass: `accdone` in cycle 1; no memory access; `result` is unchanged.
- `busy` is registered with the state: high from cycle 1 through the DONE cycle inclusive.

## Configuration
- Macro: `ACC_SATURATE_EN`.
- Defined: the add is a signed saturating add. Positive overflow clamps to 32'h7FFF_FFFF and negative overflow clamps to 32'h8000_0000. Saturation is applied at every accumulate step.
- Undefined: wrap-around two's-complement add.
- Latency is identical in both builds.

## Structure
- Shared package `acc_pkg`:
  - state enum (IDLE/READ/WRITE/DONE)
  - `ACC_ADDR_W`=6, `ACC_DATA_W`=32
  - saturation limit constants
- One sub-module, `acc_adder`: combinational DATA_W adder. Its saturating/wrapping behaviour is selected by `ACC_SATURATE_EN`.
- The FSM, pointers and memory-port muxing live in `acc_sum_engine`.

## Test plan
- Mem[4..7]=1,2,3,4; start, `startaddr`=4, `datasize`=4, `bypass`=0 → `memwe` in cycle 5 with `memaddr`=8, `memwdata`=10; `accdone` in cycle 6; `result`=10; mem[8]=10.
- Wrap: mem[62]=5, mem[63]=6, mem[0]=7; `startaddr`=62, `datasize`=3 → write 18 to word 1; `accdone` in cycle 5.
- `datasize`=0, `startaddr`=9 → 0 written to word 9 in cycle 1, `accdone` in cycle 2; bypass=1 → `accdone` in cycle 1, no `memwe`, `result` unchanged.
- Overflow: mem[0]=mem[1]=32'h7000_0000, `datasize`=2 → result 32'hE000_0000 without `ACC_SATURATE_EN`, 32'h7FFF_FFFF with it.
- `start` pulsed again during READ → ignored, single `accdone`; reset asserted in cycle 2 of a 4-word job → IDLE next cycle, no write, no `accdone`, all outputs 0.
